mem_stage: RTL

- Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM register and the WB stage.
- Receives EX/MEM register contents: res, write_data_ex, write_register_ex, zero, m_MEM, wb_MEM.
- Runs word loads and stores on a req/ack data-memory bus, stalling the pipeline while an access is outstanding.
- Drives the MEM/WB register (wb_WB, rd_WB, write_data_reg) consumed by WB and by EX forwarding.

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of a 5-stage MIPS pipeline. Performs word
//               loads/stores over a req/ack data-memory bus, stalls upstream
//               stages while an access is outstanding, aborts hung accesses
//               after TIMEOUT cycles and cancels misaligned accesses. Drives
//               the MEM/WB pipeline register.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               m_MEM, wb_MEM, res,
//               write_data_ex,
//               write_register_ex, zero    - EX/MEM register contents
//               dmem_req/we/addr/wdata     - data-memory request (registered)
//               dmem_rdata, dmem_ack       - data-memory response
//               stall, pc_src              - hazard/branch control (comb)
//               wb_WB, rd_WB,
//               write_data_reg             - MEM/WB register
//               misalign, bus_err          - one-cycle error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT     = 16,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic        zero,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        stall,
    output logic        pc_src,
    output logic        wb_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] write_data_reg,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] c_LAST_CNT = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_count;

    logic w_access;
    logic w_bad;
    logic w_last;

    assign w_access = m_MEM[1] | m_MEM[0];
    assign w_bad    = (CHECK_ALIGN != 0) && (res[1:0] != 2'b00);
    assign w_last   = (r_count == c_LAST_CNT);

    // Stall freezes upstream until the cycle in which the access resolves
    // (ack or timeout); in that cycle EX/MEM advances on the same edge.
    // Gated by rst_n so the pipeline is never held while in reset.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            if (r_state == S_IDLE)
                stall = w_access & ~w_bad;
            else
                stall = ~dmem_ack & ~w_last;
        end
    end

    assign pc_src = m_MEM[2] & zero & (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_count        <= 8'd0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_wdata     <= 32'd0;
            wb_WB          <= 1'b0;
            rd_WB          <= 5'd0;
            write_data_reg <= 32'd0;
            misalign       <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access && w_bad) begin
                        misalign       <= 1'b1;
                        wb_WB          <= 1'b0;
                        rd_WB          <= 5'd0;
                        write_data_reg <= 32'd0;
                    end else if (w_access) begin
                        // mem_read has priority when both read and write set
                        dmem_req       <= 1'b1;
                        dmem_we        <= m_MEM[0] & ~m_MEM[1];
                        dmem_addr      <= {res[31:2], 2'b00};
                        dmem_wdata     <= write_data_ex;
                        r_count        <= 8'd0;
                        r_state        <= S_ACCESS;
                        wb_WB          <= 1'b0;
                        rd_WB          <= 5'd0;
                        write_data_reg <= 32'd0;
                    end else begin
                        wb_WB          <= wb_MEM[1];
                        rd_WB          <= write_register_ex;
                        write_data_reg <= res;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        // Ack beats a coinciding timeout
                        dmem_req       <= 1'b0;
                        r_state        <= S_IDLE;
                        wb_WB          <= wb_MEM[1];
                        rd_WB          <= write_register_ex;
                        write_data_reg <= wb_MEM[0] ? dmem_rdata : res;
                    end else if (w_last) begin
                        dmem_req       <= 1'b0;
                        bus_err        <= 1'b1;
                        r_state        <= S_IDLE;
                        wb_WB          <= 1'b0;
                        rd_WB          <= 5'd0;
                        write_data_reg <= 32'd0;
                    end else begin
                        r_count        <= r_count + 8'd1;
                        wb_WB          <= 1'b0;
                        rd_WB          <= 5'd0;
                        write_data_reg <= 32'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
